// File: rtl/cpu_isa_pkg.sv
// CPU ISA definitions shared by the instruction encoder, the decoder and
// their testbenches: opcode values, the STP word and opcode classification.
package cpu_isa_pkg;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_CALL = 5'b00001;
    localparam logic [4:0] OP_RET  = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_JMPR = 5'b00100;
    localparam logic [4:0] OP_JMP  = 5'b00101;
    localparam logic [4:0] OP_ADD  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_SUB  = 5'b01010;
    localparam logic [4:0] OP_SUBI = 5'b01011;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_OR   = 5'b01110;
    localparam logic [4:0] OP_ORI  = 5'b01111;
    localparam logic [4:0] OP_ST   = 5'b10110;
    localparam logic [4:0] OP_STI  = 5'b10111;
    localparam logic [4:0] OP_STP  = 5'b11111;

    // STP with all operand fields zero; terminates a program.
    localparam logic [15:0] STP_WORD = {OP_STP, 11'h000};

    // Encoder FSM states. W0/W1 mean word 0 / the immediate is on the write port.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_W1,
        ST_TERM,
        ST_DONE,
        ST_FULL
    } enc_state_t;

    // Opcodes followed by a second word carrying immediate N.
    function automatic logic op_needs_imm(input logic [4:0] op);
        case (op)
            OP_CALL, OP_LDI, OP_JMP, OP_ADDI,
            OP_SUBI, OP_ANDI, OP_ORI, OP_STI: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Opcodes with no defined meaning in the ISA.
    function automatic logic op_is_legal(input logic [4:0] op);
        case (op)
            5'b00110, 5'b00111, 5'b10100, 5'b10101,
            5'b11001, 5'b11011, 5'b11101, 5'b11110: return 1'b0;
            default:                                return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-field handshake between a program source (loader / debug
// host) and the instruction encoder.
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs;
    logic [4:0]  in_flags;
    logic [15:0] in_imm;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_flags, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_flags, in_imm,
        output in_ready
    );

endinterface

// File: rtl/instr_field_pack.sv
// Combinational packing of instruction fields into word 0, plus the
// immediate flag. With ENC_ILLEGAL_TRAP_EN defined, illegal opcodes are
// replaced by STP, lose their immediate and raise 'trap'.
module instr_field_pack
    import cpu_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [2:0]  rd,
    input  logic [2:0]  rs,
    input  logic [4:0]  flags,
    output logic [15:0] word0,
    output logic        needs_imm,
    output logic        trap
);

    // Pack fields and classify the opcode.
    always_comb begin
        word0     = {op, rd, rs, flags};
        needs_imm = op_needs_imm(op);
        trap      = 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
        if (!op_is_legal(op)) begin
            word0     = STP_WORD;
            needs_imm = 1'b0;
            trap      = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns accepted instruction fields into 16-bit words
// (plus an optional immediate word) on the instruction RAM write port, with
// a running address, a LIMIT guard and an optional terminating STP.
// Illegal-opcode trapping is enabled by defining ENC_ILLEGAL_TRAP_EN.
module instr_encoder
    import cpu_isa_pkg::*;
#(
    parameter logic [15:0] BASE_DEFAULT = 16'h0000,
    parameter logic [15:0] LIMIT        = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_base,
    input  logic [15:0]           base_addr,
    instr_encoder_if.slave        in_if,
    input  logic                  finish,
    output logic                  wr_en,
    output logic [15:0]           wr_addr,
    output logic [15:0]           wr_data,
    output logic [15:0]           word_count,
    output logic                  busy,
    output logic                  full,
    output logic                  done,
    output logic                  err_illegal
);

    // One past LIMIT, widened so that LIMIT = 16'hFFFF does not overflow.
    localparam logic [17:0] LIMIT_P1 = {2'b00, LIMIT} + 18'd1;

    enc_state_t  state_q, state_d;
    logic [16:0] ptr_q, ptr_d;            // next unassigned address (17 bits: may pass 16'hFFFF)
    logic        imm_pend_q, imm_pend_d;
    logic [15:0] imm_q, imm_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [15:0] count_q, count_d;
    logic        busy_q, busy_d;
    logic        full_q, full_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [15:0] pk_word0;
    logic        pk_needs_imm;
    logic        pk_trap;
    logic [1:0]  need;
    logic        room;
    logic        slot_ok;
    logic        ready;
    logic        accept;
    logic        ptr_over;
    logic        do_write;
    logic [15:0] write_data;

    instr_field_pack u_pack (
        .op        (in_if.in_op),
        .rd        (in_if.in_rd),
        .rs        (in_if.in_rs),
        .flags     (in_if.in_flags),
        .word0     (pk_word0),
        .needs_imm (pk_needs_imm),
        .trap      (pk_trap)
    );

    // Acceptance: a free write slot next cycle and enough addresses for the whole instruction.
    always_comb begin
        need     = pk_needs_imm ? 2'd2 : 2'd1;
        room     = ({1'b0, ptr_q} + {16'b0, need}) <= LIMIT_P1;
        ptr_over = ptr_q > {1'b0, LIMIT};
        slot_ok  = (state_q == ST_IDLE) || (state_q == ST_W1) ||
                   ((state_q == ST_W0) && !imm_pend_q);
        ready    = slot_ok && room && !load_base;
        accept   = in_if.in_valid && ready;
    end

    assign in_if.in_ready = ready;

    // Next-state, write-port and status computation.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        imm_pend_d = imm_pend_q;
        imm_d      = imm_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        // Between writes the address port shows the next free address; it never wraps.
        wr_addr_d  = ptr_q[16] ? wr_addr_q : ptr_q[15:0];
        count_d    = count_q;
        done_d     = done_q;
        err_d      = err_q;
        do_write   = 1'b0;
        write_data = 16'h0000;

        case (state_q)
            ST_IDLE, ST_W0, ST_W1: begin
                if ((state_q == ST_W0) && imm_pend_q) begin
                    do_write   = 1'b1;
                    write_data = imm_q;
                    imm_pend_d = 1'b0;
                    state_d    = ST_W1;
                end else if (accept) begin
                    do_write   = 1'b1;
                    write_data = pk_word0;
                    imm_pend_d = pk_needs_imm;
                    imm_d      = in_if.in_imm;
                    err_d      = err_q | pk_trap;
                    state_d    = ST_W0;
                end else if (finish) begin
                    if (!ptr_over) begin
                        do_write   = 1'b1;
                        write_data = STP_WORD;
                        state_d    = ST_TERM;
                    end else begin
                        state_d = ST_FULL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TERM: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: begin
                // DONE and FULL hold until load_base.
                state_d = state_q;
            end
        endcase

        // The write just completed used the last address below or at LIMIT.
        if (wr_en_q && ptr_over && (state_q != ST_TERM)) begin
            state_d = ST_FULL;
        end
        full_d = full_q | (state_d == ST_FULL) | (wr_en_q & ptr_over);

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q[15:0];
            wr_data_d = write_data;
            ptr_d     = ptr_q + 17'd1;
            count_d   = count_q + ((count_q != 16'hFFFF) ? 16'd1 : 16'd0);
        end

        // load_base overrides everything computed above.
        if (load_base) begin
            state_d    = ST_IDLE;
            ptr_d      = {1'b0, base_addr};
            wr_addr_d  = base_addr;
            wr_en_d    = 1'b0;
            imm_pend_d = 1'b0;
            count_d    = 16'h0000;
            full_d     = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= {1'b0, BASE_DEFAULT};
            imm_pend_q <= 1'b0;
            imm_q      <= 16'h0000;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_DEFAULT;
            wr_data_q  <= 16'h0000;
            count_q    <= 16'h0000;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            imm_pend_q <= imm_pend_d;
            imm_q      <= imm_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign word_count  = count_q;
    assign busy        = busy_q;
    assign full        = full_q;
    assign done        = done_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed steps from the test plan followed by
// a randomized run, checked against a cycle-tagged queue of expected writes.
module tb_instr_encoder;

    localparam logic [15:0] LIM = 16'h00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_base = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic        finish = 1'b0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] word_count;
    logic        busy;
    logic        full;
    logic        done;
    logic        err_illegal;

    instr_encoder_if bus();

    instr_encoder #(.BASE_DEFAULT(16'h0000), .LIMIT(LIM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_base   (load_base),
        .base_addr   (base_addr),
        .in_if       (bus),
        .finish      (finish),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .word_count  (word_count),
        .busy        (busy),
        .full        (full),
        .done        (done),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  next_addr = 0;
    int  m_count = 0;
    bit  m_stopped = 1'b0;
    bit  m_err = 1'b0;

    logic [31:0] imm_mask = (32'd1 << 1) | (32'd1 << 3) | (32'd1 << 5) | (32'd1 << 9) |
                            (32'd1 << 11) | (32'd1 << 13) | (32'd1 << 15) | (32'd1 << 23);
    logic [31:0] ill_mask = (32'd1 << 6) | (32'd1 << 7) | (32'd1 << 20) | (32'd1 << 21) |
                            (32'd1 << 25) | (32'd1 << 27) | (32'd1 << 29) | (32'd1 << 30);
`ifdef ENC_ILLEGAL_TRAP_EN
    bit trap_on = 1'b1;
`else
    bit trap_on = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int c, input logic [15:0] d);
        exp_q.push_back('{c, next_addr[15:0], d});
        next_addr++;
        m_count++;
    endtask

    // One clock; then compare whatever the write port shows against the model.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 64'(wr_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                $display("write cyc=%0d addr=%h data=%h", cyc, wr_addr, wr_data);
                check("write", {32'(cyc), wr_addr, wr_data}, {32'(e.cyc), e.addr, e.data});
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missing_write", 64'(wr_en), 64'd1);
        end
    endtask

    // Offer one cycle of inputs, check in_ready, update the model, clock.
    task automatic step(input bit v, input logic [4:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [4:0] fl,
                        input logic [15:0] imm, input bit fin);
        bit          ill;
        bit          nimm;
        bit          exp_rdy;
        int          need;
        logic [15:0] w0;
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs    = rs;
        bus.in_flags = fl;
        bus.in_imm   = imm;
        finish       = fin;
        #1;
        ill     = ill_mask[op];
        nimm    = imm_mask[op] && !(trap_on && ill);
        need    = nimm ? 2 : 1;
        exp_rdy = !m_stopped && (exp_q.size() == 0) && (next_addr + need <= int'(LIM) + 1);
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        if (v && exp_rdy) begin
            w0 = (trap_on && ill) ? 16'hF800 : {op, rd, rs, fl};
            $display("accept op=%b rd=%0d rs=%0d flags=%b imm=%h", op, rd, rs, fl, imm);
            push(cyc + 1, w0);
            if (nimm) push(cyc + 2, imm);
            if (trap_on && ill) m_err = 1'b1;
        end else if (fin && exp_q.size() == 0 && !m_stopped && next_addr <= int'(LIM)) begin
            $display("finish accepted");
            push(cyc + 1, 16'hF800);
            m_stopped = 1'b1;
        end
        tick();
        bus.in_valid = 1'b0;
        finish       = 1'b0;
    endtask

    task automatic step_idle();
        step(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0);
    endtask

    task automatic do_load(input logic [15:0] base);
        load_base = 1'b1;
        base_addr = base;
        tick();
        load_base = 1'b0;
        next_addr = int'(base);
        m_count   = 0;
        m_stopped = 1'b0;
        m_err     = 1'b0;
        exp_q.delete();
    endtask

    // Status outputs at a quiet point (no write in flight).
    task automatic check_status(input string tag);
        bit over;
        over = next_addr > int'(LIM);
        check({tag, "_wr_en"},      64'(wr_en),       64'd0);
        check({tag, "_wr_addr"},    64'(wr_addr),     64'(next_addr[15:0]));
        check({tag, "_word_count"}, 64'(word_count),  64'(m_count[15:0]));
        check({tag, "_full"},       64'(full),        64'(over));
        check({tag, "_done"},       64'(done),        64'(m_stopped));
        check({tag, "_busy"},       64'(busy),        64'(m_stopped || over));
        check({tag, "_err"},        64'(err_illegal), 64'(m_err));
        check({tag, "_drained"},    64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bit          v;
        logic [4:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [4:0]  fl;
        logic [15:0] imm;

        bus.in_valid = 1'b0;
        bus.in_op    = 5'd0;
        bus.in_rd    = 3'd0;
        bus.in_rs    = 3'd0;
        bus.in_flags = 5'd0;
        bus.in_imm   = 16'h0000;

        // Reset values
        #2;
        check_status("reset");
        tick();
        tick();
        rst_n = 1'b1;
        step_idle();

        // ADD R: op 01000, rd 1, rs 2, flags 0 at address 0
        step(1'b1, 5'b01000, 3'd1, 3'd2, 5'd0, 16'h0000, 1'b0);
        step_idle();
        check_status("add");

        // JMP with immediate at base 0x0010; a NOP offered during W0 is refused
        do_load(16'h0010);
        check_status("load10");
        step(1'b1, 5'b00101, 3'd0, 3'd0, 5'd0, 16'h0123, 1'b0);
        step(1'b1, 5'b00000, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0);
        step_idle();
        check_status("jmp");

        // Five NOPs back to back
        do_load(16'h0000);
        repeat (5) step(1'b1, 5'b00000, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0);
        step_idle();
        check_status("nops");

        // At LIMIT: CALL (two words) refused, NOP fits, then full
        do_load(LIM);
        step(1'b1, 5'b00001, 3'd3, 3'd4, 5'd1, 16'hBEEF, 1'b0);
        step(1'b1, 5'b00000, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0);
        step_idle();
        check_status("limit");
        step(1'b1, 5'b00000, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0);

        // Illegal opcode 11101; load_base clears the sticky flag
        do_load(16'h0020);
        step(1'b1, 5'b11101, 3'd5, 3'd6, 5'd7, 16'h0000, 1'b0);
        step_idle();
        check_status("illegal");
        do_load(16'h0020);
        check_status("clear");

        // finish at IDLE, address 0x0007
        do_load(16'h0007);
        step(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b1);
        step_idle();
        check_status("finish");
        step(1'b1, 5'b00000, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0);

        // finish together with an accept: the instruction wins, finish held
        do_load(16'h0030);
        step(1'b1, 5'b01000, 3'd7, 3'd1, 5'd3, 16'h0000, 1'b1);
        step(1'b0, 5'd0, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b1);
        step_idle();
        check_status("fin_acc");

        // Randomized run from address 0 until LIMIT is reached
        do_load(16'h0000);
        for (int i = 0; i < 700; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = 5'($urandom);
            rd  = 3'($urandom);
            rs  = 3'($urandom);
            fl  = 5'($urandom);
            imm = 16'($urandom);
            step(v, op, rd, rs, fl, imm, 1'b0);
        end
        step_idle();
        step_idle();
        check_status("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
